// File: rtl/cache_ctrl_nway_if.sv
// Bundle between the N-way cache controller, the CPU request, the cache
// datapath and the physical memory port. The controller uses the slave
// modport; the surrounding logic (or a testbench) uses the master modport.
interface cache_ctrl_nway_if #(
  parameter int WAYS = 4,
  parameter int SETS = 8
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic             mem_read;
  logic             mem_write;
  logic [SET_W-1:0] set_idx;
  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-1:0]  valid_vec;
  logic [WAYS-1:0]  dirty_vec;
  logic             pmem_resp;

  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic [WAY_W-1:0] way_sel;
  logic             load_tag;
  logic             load_valid;
  logic             load_dirty;
  logic             dirty_in;
  logic             load_data;
  logic             data_in_sel;
  logic             wb_addr_sel;

  modport master (
    output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, way_sel, load_tag, load_valid,
           load_dirty, dirty_in, load_data, data_in_sel, wb_addr_sel
  );

  modport slave (
    input  mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
    output mem_resp, pmem_read, pmem_write, way_sel, load_tag, load_valid,
           load_dirty, dirty_in, load_data, data_in_sel, wb_addr_sel
  );
endinterface

// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// Owns the per-set tree-PLRU state, picks victims, sequences writeback and
// line fill over the pmem port and drives the array load strobes.
// Optional feature: define CACHE_PERF_CNT_EN to add saturating hit/miss/
// writeback counters (hit_cnt, miss_cnt, wb_cnt) as extra outputs.
module cache_ctrl_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                clk,
  input  logic                rst,
  cache_ctrl_nway_if.slave    bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic [31:0]         wb_cnt
`endif
);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [WAYS-2:0]   plru_q [SETS];
  logic [WAYS-2:0]   plruNext;
  logic              plruWe;

  logic              reqValid;
  logic              anyHit;
  logic              allValid;
  logic [WAY_W-1:0]  hitWay;
  logic [WAY_W-1:0]  freeWay;
  logic [WAY_W-1:0]  missVictim;

  // Walk the tree from the root following each node's bit; a 0 bit means the
  // victim lies in the lower half. The path bits, MSB first, form the way.
  function automatic logic [WAY_W-1:0] plruVictim(input logic [WAYS-2:0] bits);
    logic [WAYS-1:0]  tree;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] way;
    tree = {1'b0, bits};
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      way  = (way << 1) | WAY_W'(tree[node]);
      node = WAY_W'(2 * int'(node) + 1 + int'(tree[node]));
    end
    return way;
  endfunction

  // Point every node on the path to the accessed way away from that way.
  function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] bits,
                                                input logic [WAY_W-1:0] way);
    logic [WAYS-1:0]  tree;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] rem;
    logic             b;
    tree = {1'b0, bits};
    node = '0;
    rem  = way;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b          = rem[WAY_W-1];
      rem        = rem << 1;
      tree[node] = ~b;
      node       = WAY_W'(2 * int'(node) + 1 + int'(b));
    end
    return tree[WAYS-2:0];
  endfunction

  // Decode the addressed set: hit way, first invalid way and miss victim.
  always_comb begin
    reqValid = bus.mem_read ^ bus.mem_write;
    anyHit   = |bus.hit_vec;
    allValid = &bus.valid_vec;
    hitWay   = '0;
    freeWay  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (bus.hit_vec[w]) begin
        hitWay = WAY_W'(w);
      end
      if (!bus.valid_vec[w]) begin
        freeWay = WAY_W'(w);
      end
    end
    missVictim = allValid ? plruVictim(plru_q[bus.set_idx]) : freeWay;
  end

  // Next-state and output decode; everything defaults to idle/zero.
  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    plruWe          = 1'b0;
    plruNext        = plru_q[bus.set_idx];
    bus.mem_resp    = 1'b0;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.way_sel     = '0;
    bus.load_tag    = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_dirty  = 1'b0;
    bus.dirty_in    = 1'b0;
    bus.load_data   = 1'b0;
    bus.data_in_sel = 1'b0;
    bus.wb_addr_sel = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!reqValid) begin
          state_d = IDLE;
        end else if (anyHit) begin
          bus.mem_resp = 1'b1;
          bus.way_sel  = hitWay;
          plruWe       = 1'b1;
          plruNext     = plruTouch(plru_q[bus.set_idx], hitWay);
          if (bus.mem_write) begin
            bus.load_data  = 1'b1;
            bus.load_dirty = 1'b1;
            bus.dirty_in   = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d = missVictim;
          state_d  = bus.dirty_vec[missVictim] ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write  = 1'b1;
        bus.wb_addr_sel = 1'b1;
        bus.way_sel     = victim_q;
        if (bus.pmem_resp) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.pmem_read   = 1'b1;
        bus.way_sel     = victim_q;
        bus.data_in_sel = 1'b1;
        if (bus.pmem_resp) begin
          bus.load_tag   = 1'b1;
          bus.load_valid = 1'b1;
          bus.load_data  = 1'b1;
          bus.load_dirty = 1'b1;
          state_d        = COMPARE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched victim and PLRU storage; reset clears all of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (plruWe) begin
        plru_q[bus.set_idx] <= plruNext;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic hitEvt, missEvt, wbEvt;

  // Classify this cycle's countable events.
  always_comb begin
    hitEvt  = (state_q == COMPARE) && reqValid && anyHit;
    missEvt = (state_q == COMPARE) && reqValid && !anyHit;
    wbEvt   = (state_q == WRITEBACK) && bus.pmem_resp;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hitEvt && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (missEvt && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (wbEvt && (wb_cnt != '1)) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Testbench for cache_ctrl_nway: a driver plays CPU, datapath and pmem,
// pushing the expected events of each request into a queue; a monitor pops
// and compares whenever the controller responds or a pmem transfer ends.
module tb_cache_ctrl_nway;
  localparam int WAYS    = 4;
  localparam int SETS    = 8;
  localparam int EV_RESP = 0;
  localparam int EV_WB   = 1;
  localparam int EV_FILL = 2;

  typedef struct {
    int kind;
    int way;
    bit wr;
    int lat;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cycleNo = 0;
  int   reqCycle = 0;
  ev_t  expQ[$];
  int   plruM [SETS][WAYS-1];
  int   modelHits = 0;
  int   modelMisses = 0;
  int   modelWbs = 0;

  cache_ctrl_nway_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hitCnt, missCnt, wbCnt;
`endif

  cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hitCnt),
    .miss_cnt (missCnt),
    .wb_cnt   (wbCnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Reference replacement policy: binary search over way ranges, one flag
  // per decision point, flag 0 meaning "replace from the lower range".
  function automatic int modelVictim(input int s, input logic [WAYS-1:0] vm);
    int lo, span, node;
    for (int w = 0; w < WAYS; w++) begin
      if (!vm[w]) return w;
    end
    lo = 0; span = WAYS; node = 0;
    while (span > 1) begin
      span = span / 2;
      if (plruM[s][node] == 0) begin
        node = 2 * node + 1;
      end else begin
        lo   = lo + span;
        node = 2 * node + 2;
      end
    end
    return lo;
  endfunction

  task automatic modelTouch(input int s, input int w);
    int lo, span, node;
    lo = 0; span = WAYS; node = 0;
    while (span > 1) begin
      span = span / 2;
      if (w < lo + span) begin
        plruM[s][node] = 1;
        node = 2 * node + 1;
      end else begin
        plruM[s][node] = 0;
        lo   = lo + span;
        node = 2 * node + 2;
      end
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      for (int n = 0; n < WAYS - 1; n++) plruM[s][n] = 0;
    end
    modelHits = 0; modelMisses = 0; modelWbs = 0;
  endtask

  task automatic driveIdle();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.set_idx = '0;
    bus.hit_vec = '0; bus.valid_vec = '0; bus.dirty_vec = '0; bus.pmem_resp = 1'b0;
  endtask

  // One CPU request; hitWay < 0 means a miss. dWb/dFill are extra wait
  // cycles before pmem answers a writeback / fill.
  task automatic applyStimulus(input int s, input bit wr, input int hitWay,
                               input logic [WAYS-1:0] vm, input logic [WAYS-1:0] dm,
                               input int dWb, input int dFill);
    ev_t e;
    int  victim, wCnt, fCnt;
    bit  dirtyVictim, seen, done;
    victim = 0;
    if (hitWay >= 0) begin
      e = '{kind: EV_RESP, way: hitWay, wr: wr, lat: 1};
      expQ.push_back(e);
      modelTouch(s, hitWay);
      modelHits++;
    end else begin
      victim      = modelVictim(s, vm);
      dirtyVictim = dm[victim];
      modelMisses++;
      if (dirtyVictim) begin
        e = '{kind: EV_WB, way: victim, wr: wr, lat: 0};
        expQ.push_back(e);
        modelWbs++;
      end
      e = '{kind: EV_FILL, way: victim, wr: wr, lat: 0};
      expQ.push_back(e);
      e = '{kind: EV_RESP, way: victim, wr: wr,
            lat: 3 + dFill + (dirtyVictim ? dWb + 1 : 0)};
      expQ.push_back(e);
      modelTouch(s, victim);
      modelHits++;
    end
    @(posedge clk); #1;
    bus.set_idx   = 3'(s);
    bus.valid_vec = vm;
    bus.dirty_vec = dm;
    bus.hit_vec   = (hitWay >= 0) ? (WAYS'(1) << hitWay) : '0;
    bus.mem_read  = !wr;
    bus.mem_write = wr;
    reqCycle      = cycleNo;
    wCnt = 0; fCnt = 0; seen = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (seen) begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit_vec = '0;
        done = 1;
      end else if (bus.mem_resp) begin
        seen = 1;
      end else if (bus.pmem_write) begin
        if (wCnt == dWb) bus.pmem_resp = 1'b1;
        else wCnt++;
      end else if (bus.pmem_read) begin
        if (fCnt == dFill) begin
          bus.pmem_resp = 1'b1;
          bus.hit_vec   = WAYS'(1) << victim;
          bus.valid_vec = bus.valid_vec | (WAYS'(1) << victim);
          bus.dirty_vec = bus.dirty_vec & ~(WAYS'(1) << victim);
        end else begin
          fCnt++;
        end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL requestTimeout actual=no mem_resp required=mem_resp set=%0d", s);
      driveIdle();
    end
  endtask

  task automatic applyIllegal();
    @(posedge clk); #1;
    bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.hit_vec = 4'b0001; bus.valid_vec = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("illegalIgnored", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 0);
    end
    driveIdle();
  endtask

  // Reset asserted while a fill is outstanding.
  task automatic applyAbort();
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    bus.set_idx = '0; bus.valid_vec = '1; bus.dirty_vec = '0; bus.hit_vec = '0;
    bus.mem_read = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.pmem_read) seen = 1;
    end
    checkOutput("abortReachedFill", seen, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortOutputs", {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_tag,
                                 bus.load_valid, bus.load_data, bus.load_dirty}, 0);
    rst = 1'b0;
    driveIdle();
    modelReset();
  endtask

  // Monitor: pop and compare on every response or completed pmem transfer.
  always @(negedge clk) begin : monitor
    ev_t        e;
    int         obsKind;
    logic [6:0] expStr;
    if (!rst) begin
      checkOutput("pmemExclusive", 64'(bus.pmem_read & bus.pmem_write), 0);
      if (bus.mem_resp || (bus.pmem_resp && (bus.pmem_read || bus.pmem_write))) begin
        obsKind = bus.mem_resp ? EV_RESP : (bus.pmem_write ? EV_WB : EV_FILL);
        if (expQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpectedEvent actual kind=%0d required=none", obsKind);
        end else begin
          e = expQ.pop_front();
          checkOutput("eventKind", obsKind, e.kind);
          checkOutput("eventWay", bus.way_sel, e.way);
          case (e.kind)
            EV_RESP: expStr = e.wr ? 7'b0001110 : 7'b0000000;
            EV_WB:   expStr = 7'b1000000;
            default: expStr = 7'b0111101;
          endcase
          checkOutput("eventStrobes", {bus.wb_addr_sel, bus.load_tag, bus.load_valid, bus.load_data,
                                       bus.load_dirty, bus.dirty_in, bus.data_in_sel}, expStr);
          if (e.kind == EV_RESP) checkOutput("respLatency", cycleNo - reqCycle, e.lat);
        end
      end else begin
        checkOutput("quietStrobes", {bus.load_tag, bus.load_valid, bus.load_data,
                                     bus.load_dirty, bus.dirty_in}, 0);
      end
    end
  end

  initial begin
    int s, hw, dWb, dFill;
    bit wr;
    logic [WAYS-1:0] vm, dm;
    driveIdle();
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("resetOutputs", {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.way_sel,
                                 bus.load_tag, bus.load_valid, bus.load_dirty, bus.dirty_in,
                                 bus.load_data, bus.data_in_sel, bus.wb_addr_sel}, 0);
    $display("[TB] directed requests");
    applyStimulus(3, 0, 1, 4'b0010, 4'b0000, 0, 0);
    applyStimulus(0, 0, -1, 4'b1111, 4'b0000, 0, 2);
    applyStimulus(0, 0, 0, 4'b1111, 4'b0000, 0, 0);
    applyStimulus(0, 0, -1, 4'b1111, 4'b0000, 0, 1);
    applyStimulus(5, 1, -1, 4'b1111, 4'b1111, 2, 1);
    applyStimulus(2, 1, 3, 4'b1000, 4'b0000, 0, 0);
    applyStimulus(4, 0, -1, 4'b1011, 4'b1011, 0, 0);
    applyIllegal();
    applyAbort();
    applyStimulus(0, 0, -1, 4'b1111, 4'b0000, 0, 0);
    $display("[TB] random requests");
    for (int n = 0; n < 150; n++) begin
      s     = $urandom_range(0, SETS - 1);
      wr    = 1'($urandom_range(0, 1));
      dWb   = $urandom_range(0, 3);
      dFill = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        hw = $urandom_range(0, WAYS - 1);
        vm = WAYS'($urandom) | (WAYS'(1) << hw);
      end else begin
        hw = -1;
        vm = ($urandom_range(0, 2) == 0) ? WAYS'($urandom) : '1;
      end
      dm = WAYS'($urandom) & vm;
      applyStimulus(s, wr, hw, vm, dm, dWb, dFill);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);
`ifdef CACHE_PERF_CNT_EN
    checkOutput("hitCnt", hitCnt, modelHits);
    checkOutput("missCnt", missCnt, modelMisses);
    checkOutput("wbCnt", wbCnt, modelWbs);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
